// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multiply/divide scheduler.
//   state_e             - scheduler FSM state encoding
//   OP_MULT / OP_DIV    - req_op encodings
//   TIMEOUT_CYCLES_DEF  - default watchdog limit in RUN cycles
//   CNT_W_DEF           - default watchdog counter width
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_RUN    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_EXCP   = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 40;
  localparam int CNT_W_DEF          = 6;

endpackage

// File: rtl/muldiv_sched_if.sv
// muldiv_sched_if: bundles the control-unit request handshake, the engine
// start/done signals and the HI/LO write controls of the scheduler.
//   slave  - scheduler view (drives starts, HI/LO controls and status)
//   master - environment view (control unit plus the two engines)
interface muldiv_sched_if;
  logic        req_valid;
  logic        req_op;
  logic [31:0] req_b;
  logic        req_ready;
  logic        mult_start;
  logic        div_start;
  logic        mult_done;
  logic        div_done;
  logic        div_zero;
  logic        hilo_sel;
  logic        hi_write;
  logic        lo_write;
  logic        busy;
  logic        done;
  logic        div0_excp;
  logic        timeout_err;

  modport slave (
    input  req_valid, req_op, req_b, mult_done, div_done, div_zero,
    output req_ready, mult_start, div_start, hilo_sel, hi_write, lo_write,
           busy, done, div0_excp, timeout_err
  );

  modport master (
    output req_valid, req_op, req_b, mult_done, div_done, div_zero,
    input  req_ready, mult_start, div_start, hilo_sel, hi_write, lo_write,
           busy, done, div0_excp, timeout_err
  );
endinterface

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: counts enabled cycles and flags expiry.
//   clk, rst_n  - clock, async active-low reset
//   clr_i       - synchronous clear (priority over enable)
//   en_i        - count this cycle
//   expired_o   - high in the enabled cycle whose increment makes the count
//                 reach TIMEOUT_CYCLES (i.e. the TIMEOUT_CYCLES-th enabled cycle)
// TIMEOUT_CYCLES must be below 2**CNT_W.
module muldiv_watchdog #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: sequences one multiply or divide at a time, issues the engine
// start pulse, guards the run with a watchdog and commits HI/LO.
//   clk, rst_n - clock, async active-low reset
//   bus        - muldiv_sched_if.slave: request handshake, engine start/done,
//                HI/LO write controls and status pulses
// Optional build macro MULDIV_DIV0_PRECHECK_EN: a DIV request with req_b == 0
// goes straight from IDLE to EXCP without starting the divider.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request
// ISSUE  | one-cycle start pulse to the selected engine, watchdog cleared
// RUN    | waiting for the selected engine's done, watchdog counting
// COMMIT | one-cycle HI/LO write and done pulse
// EXCP   | one-cycle divide-by-zero exception pulse, no HI/LO write
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  muldiv_sched_if.slave  bus
);

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   sel_done;
  logic   wd_clr, wd_en, wd_expired;
  logic   div0_pre;

  logic req_ready_o, mult_start_o, div_start_o, hilo_sel_o;
  logic hi_write_o, lo_write_o, busy_o, done_o, div0_excp_o, timeout_err_o;

`ifdef MULDIV_DIV0_PRECHECK_EN
  assign div0_pre = (bus.req_op == OP_DIV) && (bus.req_b == 32'd0);
`else
  logic unused_req_b;
  assign unused_req_b = ^bus.req_b;
  assign div0_pre     = 1'b0;
`endif

  // Only the engine that was started is listened to.
  assign sel_done = (op_q == OP_DIV) ? bus.div_done : bus.mult_done;

  // Counter is held at zero outside RUN, so ISSUE always leaves it cleared.
  assign wd_en  = (state_q == ST_RUN);
  assign wd_clr = (state_q != ST_RUN);

  muldiv_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          state_d = div0_pre ? ST_EXCP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_RUN;
      ST_RUN: begin
        // done takes priority over a simultaneous watchdog expiry
        if (sel_done) begin
          state_d = ((op_q == OP_DIV) && bus.div_zero) ? ST_EXCP : ST_COMMIT;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_EXCP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = 1'b0;
    mult_start_o  = 1'b0;
    div_start_o   = 1'b0;
    hilo_sel_o    = op_q;
    hi_write_o    = 1'b0;
    lo_write_o    = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    div0_excp_o   = 1'b0;
    timeout_err_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        hilo_sel_o  = 1'b0;
      end
      ST_ISSUE: begin
        mult_start_o = (op_q == OP_MULT);
        div_start_o  = (op_q == OP_DIV);
      end
      ST_RUN: begin
        timeout_err_o = wd_expired && !sel_done;
      end
      ST_COMMIT: begin
        hi_write_o = 1'b1;
        lo_write_o = 1'b1;
        done_o     = 1'b1;
      end
      ST_EXCP: begin
        div0_excp_o = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  assign bus.req_ready   = req_ready_o;
  assign bus.mult_start  = mult_start_o;
  assign bus.div_start   = div_start_o;
  assign bus.hilo_sel    = hilo_sel_o;
  assign bus.hi_write    = hi_write_o;
  assign bus.lo_write    = lo_write_o;
  assign bus.busy        = busy_o;
  assign bus.done        = done_o;
  assign bus.div0_excp   = div0_excp_o;
  assign bus.timeout_err = timeout_err_o;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed test of muldiv_sched. Inputs change 2 time units
// after the rising edge, outputs are sampled 1 unit later.
module tb_muldiv_sched;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  muldiv_sched_if bus ();

  muldiv_sched #(
    .TIMEOUT_CYCLES (40),
    .CNT_W          (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output bundle bit order:
  // [9] req_ready [8] mult_start [7] div_start [6] hilo_sel [5] hi_write
  // [4] lo_write  [3] busy       [2] done      [1] div0_excp [0] timeout_err
  localparam logic [9:0] EXP_IDLE     = 10'h200;
  localparam logic [9:0] EXP_ISSUE_D  = 10'h0C8;
  localparam logic [9:0] EXP_RUN_D    = 10'h048;
  localparam logic [9:0] EXP_COMMIT_D = 10'h07C;

  function automatic logic [9:0] outs();
    return {bus.req_ready, bus.mult_start, bus.div_start, bus.hilo_sel,
            bus.hi_write, bus.lo_write, bus.busy, bus.done, bus.div0_excp,
            bus.timeout_err};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // results of the last transaction
  int r_busy, r_ms, r_ds, r_hw, r_lw, r_done, r_d0, r_to, r_hilo_bad, r_s;
  logic r_fin;

  // Issues one request and follows it until busy drops. run_done is the RUN
  // cycle (1-based) on which the selected engine reports done, 0 = never.
  // spur raises the other engine's done on RUN cycles 1..3.
  task automatic txn(input logic op, input logic [31:0] b, input int run_done,
                     input logic dz, input logic spur, input logic hold);
    r_busy = 0; r_ms = 0; r_ds = 0; r_hw = 0; r_lw = 0; r_done = 0;
    r_d0 = 0; r_to = 0; r_hilo_bad = 0; r_s = -1; r_fin = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_b     = b;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!hold) bus.req_valid = 1'b0;
      bus.mult_done = 1'b0;
      bus.div_done  = 1'b0;
      bus.div_zero  = 1'b0;
      if (r_s >= 0 && run_done > 0 && i == r_s + run_done) begin
        if (op) begin
          bus.div_done = 1'b1;
          bus.div_zero = dz;
        end else begin
          bus.mult_done = 1'b1;
        end
      end
      if (spur && r_s >= 0 && i > r_s && i <= r_s + 3) begin
        if (op) begin
          bus.mult_done = 1'b1;
        end else begin
          bus.div_done = 1'b1;
          bus.div_zero = 1'b1;
        end
      end
      #1;
      if ((bus.mult_start || bus.div_start) && r_s < 0) r_s = i;
      r_ms   += int'(bus.mult_start);
      r_ds   += int'(bus.div_start);
      r_hw   += int'(bus.hi_write);
      r_lw   += int'(bus.lo_write);
      r_done += int'(bus.done);
      r_d0   += int'(bus.div0_excp);
      r_to   += int'(bus.timeout_err);
      if (bus.busy) begin
        r_busy++;
        if (bus.hilo_sel !== op) r_hilo_bad++;
      end else begin
        r_fin = 1'b1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    bus.mult_done = 1'b0;
    bus.div_done  = 1'b0;
    bus.div_zero  = 1'b0;
  endtask

  task automatic expect_txn(input string tag, input int busy_n, input int ms,
                            input int ds, input int hw, input int dn,
                            input int d0, input int to);
    chk({tag, "_finished"}, int'(r_fin), 1);
    chk({tag, "_busy_cycles"}, r_busy, busy_n);
    chk({tag, "_mult_start"}, r_ms, ms);
    chk({tag, "_div_start"}, r_ds, ds);
    chk({tag, "_hi_write"}, r_hw, hw);
    chk({tag, "_lo_write"}, r_lw, hw);
    chk({tag, "_done"}, r_done, dn);
    chk({tag, "_div0_excp"}, r_d0, d0);
    chk({tag, "_timeout_err"}, r_to, to);
    chk({tag, "_hilo_sel"}, r_hilo_bad, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_b     = 32'd0;
    bus.mult_done = 1'b0;
    bus.div_done  = 1'b0;
    bus.div_zero  = 1'b0;

    // reset state
    #1 rst_n = 1'b0;
    #2 chk("reset_outputs", int'(outs()), int'(EXP_IDLE));
    #9 rst_n = 1'b1;
    tick();
    #1 chk("idle_after_release", int'(outs()), int'(EXP_IDLE));

    // MULT, engine latency 33: done on RUN cycle 34, busy 36 cycles
    txn(1'b0, 32'd7, 34, 1'b0, 1'b0, 1'b0);
    chk("mult33_first_edge_accept", r_s, 0);
    expect_txn("mult33", 36, 1, 0, 1, 1, 0, 0);

    // DIV cycle by cycle, done on RUN cycle 2
    bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_b = 32'd5;
    tick();
    bus.req_valid = 1'b0;
    #1 chk("div_issue", int'(outs()), int'(EXP_ISSUE_D));
    tick();
    #1 chk("div_run1", int'(outs()), int'(EXP_RUN_D));
    tick();
    bus.div_done = 1'b1;
    #1 chk("div_run2_done", int'(outs()), int'(EXP_RUN_D));
    tick();
    bus.div_done = 1'b0;
    #1 chk("div_commit", int'(outs()), int'(EXP_COMMIT_D));
    tick();
    #1 chk("div_back_idle", int'({bus.req_ready, bus.busy}), 2);

    // DIV normal, done on RUN cycle 3
    txn(1'b1, 32'd9, 3, 1'b0, 1'b0, 1'b0);
    expect_txn("div_ok", 5, 0, 1, 1, 1, 0, 0);

    // DIV with engine-reported zero divisor
    txn(1'b1, 32'd3, 5, 1'b1, 1'b0, 1'b0);
    expect_txn("div_zero", 7, 0, 1, 0, 0, 1, 0);

    // DIV with req_b == 0 while the engine would report success
    txn(1'b1, 32'd0, 3, 1'b0, 1'b0, 1'b0);
`ifdef MULDIV_DIV0_PRECHECK_EN
    expect_txn("div_b0", 1, 0, 0, 0, 0, 1, 0);
`else
    expect_txn("div_b0", 5, 0, 1, 1, 1, 0, 0);
`endif

    // watchdog: no done for 40 RUN cycles
    txn(1'b0, 32'd1, 0, 1'b0, 1'b0, 1'b0);
    expect_txn("timeout", 41, 1, 0, 0, 0, 0, 1);

    // done on the 40th RUN cycle wins over expiry
    txn(1'b0, 32'd1, 40, 1'b0, 1'b0, 1'b0);
    expect_txn("done_at_40", 42, 1, 0, 1, 1, 0, 0);

    // req_valid held high and spurious div_done/div_zero during a MULT
    txn(1'b0, 32'd2, 8, 1'b0, 1'b1, 1'b1);
    expect_txn("hold_spur", 10, 1, 0, 1, 1, 0, 0);

    // reset asserted mid-RUN
    bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.req_b = 32'd4;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    #1 chk("pre_reset_run", int'(outs()), 8);
    rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'(outs()), int'(EXP_IDLE));
    tick();
    rst_n = 1'b1;
    txn(1'b0, 32'd4, 4, 1'b0, 1'b0, 1'b0);
    chk("post_reset_first_edge", r_s, 0);
    expect_txn("post_reset_mult", 6, 1, 0, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 40, giving the maximum cycles an engine may run before a timeout error.
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the watchdog counter width; TIMEOUT_CYCLES SHALL be less than 2**CNT_W.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clock  input  1  system clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous active-low reset.
REQ-006 Port req_valid  input  1  the control unit requests an operation.
REQ-007 Port req_op  input  1  operation select: 0 = MULT, 1 = DIV.
REQ-008 Port req_b  input  32  divisor/multiplier operand, used only by the divide-by-zero precheck.
REQ-009 Port req_ready  output  1  high only in IDLE.
REQ-010 Port mult_start  output  1  one-cycle start pulse to the multiplier.
REQ-011 Port div_start  output  1  one-cycle start pulse to the divider.
REQ-012 Port mult_done  input  1  multiplier finished (ciclos_end).
REQ-013 Port div_done  input  1  divider finished.
REQ-014 Port div_zero  input  1  divider reports a zero divisor; valid with div_done.
REQ-015 Port hilo_sel  output  1  HI/LO source mux: 0 = multiplier, 1 = divider.
REQ-016 Port hi_write  output  1  HI register write enable.
REQ-017 Port lo_write  output  1  LO register write enable.
REQ-018 Port busy  output  1  high in any state other than IDLE.
REQ-019 Port done  output  1  one-cycle pulse on successful commit.
REQ-020 Port div0_excp  output  1  one-cycle divide-by-zero exception pulse.
REQ-021 Port timeout_err  output  1  one-cycle watchdog expiry pulse.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, RUN, COMMIT and EXCP.
REQ-023 In IDLE, a cycle with req_valid=1 SHALL accept the request: latch req_op into op_r and go to ISSUE.
REQ-024 In ISSUE, the block SHALL assert mult_start (op_r=0) or div_start (op_r=1) for exactly one cycle, clear the watchdog and go to RUN.
REQ-025 In RUN, the block SHALL increment the watchdog each cycle and watch only the done input of the selected engine; the other engine's done SHALL be ignored.
REQ-026 On the selected done in RUN, the block SHALL go to COMMIT, or to EXCP when op_r=1 and div_zero=1.
REQ-027 When the watchdog reaches TIMEOUT_CYCLES with no done, the block SHALL pulse timeout_err and return to IDLE with no HI/LO write.
REQ-028 When done and watchdog expiry occur in the same cycle, done SHALL win and no timeout_err SHALL be raised.
REQ-029 In COMMIT, the block SHALL assert hi_write, lo_write and done for exactly one cycle, then return to IDLE.
REQ-030 In EXCP, the block SHALL assert div0_excp for exactly one cycle with hi_write=lo_write=0, then return to IDLE.
REQ-031 hilo_sel SHALL equal op_r in every state except IDLE.
REQ-032 Requests arriving while busy SHALL be ignored and not queued.
REQ-033 Minimum accept-to-done latency SHALL be engine latency plus 3 cycles (ISSUE, first RUN, COMMIT).

Reset
REQ-034 Asserting reset at any time, including mid-operation, SHALL force IDLE with watchdog=0, op_r=0 and all outputs low except req_ready=1.
REQ-035 After reset release, the first request SHALL be accepted on the first rising edge with req_valid=1.

Configuration
REQ-036 With MULDIV_DIV0_PRECHECK_EN defined, a DIV request with req_b==0 SHALL go from IDLE directly to EXCP, so div_start is never pulsed.
REQ-037 Without MULDIV_DIV0_PRECHECK_EN, req_b SHALL be unused and divide-by-zero SHALL be detected only through div_zero.

Structure
REQ-038 Package muldiv_pkg SHALL hold the state enum, the OP_MULT/OP_DIV encodings and the default TIMEOUT_CYCLES.
REQ-039 The watchdog SHALL be a sub-module muldiv_watchdog with clear, enable and expired outputs.

Verification
REQ-040 MULT request with mult_done 33 cycles after mult_start -> one hi_write/lo_write/done pulse with hilo_sel=0; busy for 36 cycles.
REQ-041 DIV request with div_done=1 and div_zero=1 -> div0_excp pulse and no HI/LO write; with the macro defined and req_b=0 -> EXCP immediately and div_start never asserted.
REQ-042 No done for 40 RUN cycles -> timeout_err pulse and return to IDLE; done on cycle 40 -> commit and no timeout_err.
REQ-043 reset driven low during RUN -> all outputs cleared asynchronously; a subsequent MULT request completes normally.
REQ-044 req_valid held high during RUN and a spurious div_done during a MULT -> no extra start pulses and no early commit.
